// File: rtl/bp_pkg.sv
// bp_pkg: shared 2-bit saturating counter encodings for the branch predictor.
package bp_pkg;
    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_RESET = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;
endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: combinational next state of a 2-bit saturating direction counter.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_next_o
);
    always_comb
        ctr_next_o = taken_i ? ((ctr_i == CTR_ST)  ? CTR_ST  : ctr_i + 2'd1)
                             : ((ctr_i == CTR_SNT) ? CTR_SNT : ctr_i - 2'd1);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, combinational lookup,
// execute-stage training, mispredict detection and performance counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      PCF,
    output logic             PredTakenF,
    output logic [31:0]      PredTargetF,
    input  logic             BranchE,
    input  logic [31:0]      PCE,
    input  logic             TakenE,
    input  logic [31:0]      TargetE,
    input  logic             PredTakenE,
    input  logic [31:0]      PredTargetE,
    output logic             MispredictE,
    output logic [31:0]      CorrectPCE,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] MispredCount
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

    logic [IDX_W-1:0] f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             f_hit, e_hit;
    logic [1:0]       ctr_d;
    logic             unused_pc;

    assign unused_pc = ^{PCF[1:0], PCE[1:0]};
    assign f_idx = PCF[IDX_W+1:2];
    assign f_tag = PCF[31:IDX_W+2];
    assign e_idx = PCE[IDX_W+1:2];
    assign e_tag = PCE[31:IDX_W+2];
    assign f_hit = valid_q[f_idx] && tag_q[f_idx] == f_tag;
    assign e_hit = valid_q[e_idx] && tag_q[e_idx] == e_tag;

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign PredTakenF   = f_hit && ctr_q[f_idx][1];
    assign PredTargetF  = PredTakenF ? target_q[f_idx] : '0;
    assign MispredictE  = BranchE && (PredTakenE != TakenE || (TakenE && PredTargetE != TargetE));
    assign CorrectPCE   = TakenE ? TargetE : PCE + 32'd4;
    assign BranchCount  = branch_cnt_q;
    assign MispredCount = mispred_cnt_q;

    bp_sat_counter u_ctr (
        .ctr_i      (ctr_q[e_idx]),
        .taken_i    (TakenE),
        .ctr_next_o (ctr_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (BranchE) begin
                branch_cnt_q <= branch_cnt_q + CNT_W'(1);
                if (e_hit) begin
                    ctr_q[e_idx] <= ctr_d;
                    if (TakenE) target_q[e_idx] <= TargetE;
                end else if (TakenE) begin
                    valid_q[e_idx]  <= 1'b1;
                    tag_q[e_idx]    <= e_tag;
                    target_q[e_idx] <= TargetE;
                    ctr_q[e_idx]    <= CTR_ALLOC;
                end
            end
            if (MispredictE) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and random checks of branch_predictor against a
// table model indexed by word address (ENTRIES=16, CNT_W=4).
module tb_branch_predictor;
    localparam int NE  = 16;
    localparam int MOD = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] PCF = '0, PCE = '0, TargetE = '0, PredTargetE = '0;
    logic        BranchE = 1'b0, TakenE = 1'b0, PredTakenE = 1'b0;
    logic        PredTakenF, MispredictE;
    logic [31:0] PredTargetF, CorrectPCE;
    logic [3:0]  BranchCount, MispredCount;

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_valid [NE];
    int unsigned m_tag   [NE];
    logic [31:0] m_tgt   [NE];
    int          m_ctr   [NE];
    int          m_bc, m_mc;

    branch_predictor #(.ENTRIES(16), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .PCF(PCF),
        .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .BranchE(BranchE), .PCE(PCE), .TakenE(TakenE), .TargetE(TargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
        .MispredictE(MispredictE), .CorrectPCE(CorrectPCE),
        .BranchCount(BranchCount), .MispredCount(MispredCount)
    );

    always #5 clk = ~clk;

    function automatic int midx(logic [31:0] pc);
        return int'((pc / 4) % NE);
    endfunction

    function automatic bit mhit(logic [31:0] pc);
        return m_valid[midx(pc)] && m_tag[midx(pc)] == pc / 64;
    endfunction

    function automatic bit mpred(logic [31:0] pc);
        return mhit(pc) && m_ctr[midx(pc)] >= 2;
    endfunction

    function automatic logic [31:0] mtarget(logic [31:0] pc);
        return mpred(pc) ? m_tgt[midx(pc)] : 32'h0;
    endfunction

    function automatic bit mmis();
        return BranchE && (PredTakenE != TakenE || (TakenE && PredTargetE != TargetE));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_bc = 0; m_mc = 0;
    endtask

    task automatic model_update();
        int i;
        i = midx(PCE);
        if (!BranchE) return;
        m_bc = (m_bc + 1) % MOD;
        if (mmis()) m_mc = (m_mc + 1) % MOD;
        if (mhit(PCE)) begin
            if (TakenE) begin
                m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = TargetE;
            end else
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end else if (TakenE) begin
            m_valid[i] = 1; m_tag[i] = PCE / 64; m_tgt[i] = TargetE; m_ctr[i] = 2;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        #1;
        chk({tag, ".pred"}, 32'(PredTakenF), 32'(mpred(PCF)));
        chk({tag, ".tgt"}, PredTargetF, mtarget(PCF));
        chk({tag, ".mis"}, 32'(MispredictE), 32'(mmis()));
        if (BranchE) chk({tag, ".cpc"}, CorrectPCE, TakenE ? TargetE : PCE + 32'd4);
        chk({tag, ".bc"}, 32'(BranchCount), 32'(m_bc));
        chk({tag, ".mc"}, 32'(MispredCount), 32'(m_mc));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_update();
        #1;
    endtask

    task automatic br(logic [31:0] pce, logic tk, logic [31:0] tgt, logic pt, logic [31:0] ptg);
        BranchE = 1'b1; PCE = pce; TakenE = tk; TargetE = tgt; PredTakenE = pt; PredTargetE = ptg;
    endtask

    task automatic idle();
        BranchE = 1'b0; TakenE = 1'b0; PredTakenE = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        reset_n = 1'b1;
        PCF = 32'h100;
        check_all("reset");
        chk("reset.const", 32'(PredTakenF), 32'h0);

        // Allocation: 0x100 taken to 0x200, not predicted
        br(32'h100, 1, 32'h200, 0, 0);
        check_all("alloc");
        chk("alloc.mis_c", 32'(MispredictE), 32'h1);
        chk("alloc.cpc_c", CorrectPCE, 32'h200);
        tick(); idle();
        check_all("alloc.look");
        chk("alloc.tgt_c", PredTargetF, 32'h200);
        for (int k = 0; k < 2; k++) begin
            br(32'h100, 1, 32'h200, 1, 32'h200); check_all("sat"); tick();
        end
        // Hysteresis from strong-taken
        br(32'h100, 0, 32'h0, 1, 32'h200); check_all("hyst1"); tick(); idle();
        check_all("hyst1.look");
        chk("hyst1.c", 32'(PredTakenF), 32'h1);
        br(32'h100, 0, 32'h0, 1, 32'h200);
        check_all("hyst2");
        chk("hyst2.mis_c", 32'(MispredictE), 32'h1);
        chk("hyst2.cpc_c", CorrectPCE, 32'h104);
        tick(); idle();
        check_all("hyst2.look");
        chk("hyst2.c", 32'(PredTakenF), 32'h0);

        // Aliasing at index 0
        br(32'h100, 1, 32'h200, 0, 0); check_all("alias0"); tick();
        br(32'h140, 1, 32'h300, 0, 0); check_all("alias1"); tick(); idle();
        PCF = 32'h100; check_all("alias.miss");
        chk("alias.miss_c", 32'(PredTakenF), 32'h0);
        PCF = 32'h140; check_all("alias.hit");
        chk("alias.hit_c", PredTargetF, 32'h300);

        // Target change on a hit
        br(32'h140, 1, 32'h280, 1, 32'h300); check_all("tchg");
        chk("tchg.mis_c", 32'(MispredictE), 32'h1);
        tick(); idle();
        check_all("tchg.look");
        chk("tchg.c", PredTargetF, 32'h280);

        // Same-cycle lookup and update: old target returned
        br(32'h140, 1, 32'h3c0, 1, 32'h280);
        check_all("same");
        chk("same.c", PredTargetF, 32'h280);
        tick(); idle();
        check_all("same.after");

        // PC+4 wraps at the top of the address space
        br(32'hffff_fffc, 0, 32'h0, 0, 0);
        check_all("wrap");
        chk("wrap.c", CorrectPCE, 32'h0);
        tick(); idle();

        // Reset asserted while a branch resolves discards it
        br(32'h180, 1, 32'h500, 0, 0);
        #1 reset_n = 1'b0;
        model_reset();
        check_all("rst.mid");
        tick();
        reset_n = 1'b1; idle();
        PCF = 32'h180;
        check_all("rst.after");
        chk("rst.bc_c", 32'(BranchCount), 32'h0);

        // 17 branches wrap a 4-bit counter to 1
        for (int k = 0; k < 17; k++) begin
            br(32'($urandom_range(0, 255)) * 4, 0, 0, 0, 0); tick();
        end
        idle();
        check_all("cwrap");
        chk("cwrap.c", 32'(BranchCount), 32'h1);

        for (int k = 0; k < 400; k++) begin
            logic [31:0] pc;
            logic        pt;
            pc = 32'($urandom_range(0, 191)) * 4;
            if ($urandom_range(0, 9) == 0) pc = 32'hffff_ff00 | pc[7:0];
            pt = mpred(pc);
            if ($urandom_range(0, 3) == 0) pt = ~pt;
            if ($urandom_range(0, 4) == 0) idle();
            else br(pc, 1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 7)) * 4,
                    pt, pt ? mtarget(pc) : 32'h0);
            PCF = $urandom_range(0, 3) == 0 ? pc : 32'($urandom_range(0, 191)) * 4;
            check_all("rand");
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
